// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: four clients share one server port, and one transaction is in flight at a time.
// Define BUS_ARB_ROUND_ROBIN_EN for round-robin grant order; the default build uses fixed priority 1 > 2 > 3 > 4.
module bus_arbiter_rr #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] client_1_address,
   input  logic                  client_1_rq,
   input  logic                  client_1_wr_ni,
   input  logic [DATA_WIDTH-1:0] client_1_dataW,
   output logic                  client_1_ack,
   output logic [DATA_WIDTH-1:0] client_1_dataR,
   input  logic [ADDR_WIDTH-1:0] client_2_address,
   input  logic                  client_2_rq,
   input  logic                  client_2_wr_ni,
   input  logic [DATA_WIDTH-1:0] client_2_dataW,
   output logic                  client_2_ack,
   output logic [DATA_WIDTH-1:0] client_2_dataR,
   input  logic [ADDR_WIDTH-1:0] client_3_address,
   input  logic                  client_3_rq,
   input  logic                  client_3_wr_ni,
   input  logic [DATA_WIDTH-1:0] client_3_dataW,
   output logic                  client_3_ack,
   output logic [DATA_WIDTH-1:0] client_3_dataR,
   input  logic [ADDR_WIDTH-1:0] client_4_address,
   input  logic                  client_4_rq,
   input  logic                  client_4_wr_ni,
   input  logic [DATA_WIDTH-1:0] client_4_dataW,
   output logic                  client_4_ack,
   output logic [DATA_WIDTH-1:0] client_4_dataR,
   output logic [ADDR_WIDTH-1:0] server_address,
   output logic                  server_rq,
   output logic                  server_wr_ni,
   output logic [DATA_WIDTH-1:0] server_dataW,
   input  logic                  server_ack,
   input  logic [DATA_WIDTH-1:0] server_dataR,
   output logic [3:0]            grant,
   output logic [1:0]            fsm_state
);

   // Handshake: a client raises rq with address/wr_ni/dataW and holds it until it sees ack. It then drops rq,
   // and ack, dataR and grant clear on the next edge. server_rq stays high until server_ack is sampled.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SRV_REQ = 2'd1,
      CLI_ACK = 2'd2
   } state_t;

   state_t                     state;
   logic [3:0]                 rq;
   logic [3:0][ADDR_WIDTH-1:0] addr_in;
   logic [3:0]                 wr_ni_in;
   logic [3:0][DATA_WIDTH-1:0] data_w_in;
   logic [3:0]                 ack;
   logic [3:0][DATA_WIDTH-1:0] data_r;
   logic [3:0]                 pick;
   logic [1:0]                 win_idx;
   logic [1:0]                 owner;

   assign rq        = {client_4_rq, client_3_rq, client_2_rq, client_1_rq};
   assign addr_in   = {client_4_address, client_3_address, client_2_address, client_1_address};
   assign wr_ni_in  = {client_4_wr_ni, client_3_wr_ni, client_2_wr_ni, client_1_wr_ni};
   assign data_w_in = {client_4_dataW, client_3_dataW, client_2_dataW, client_1_dataW};

   assign {client_4_ack, client_3_ack, client_2_ack, client_1_ack} = ack;
   assign client_1_dataR = data_r[0];
   assign client_2_dataR = data_r[1];
   assign client_3_dataR = data_r[2];
   assign client_4_dataR = data_r[3];
   assign fsm_state      = state;

`ifdef BUS_ARB_ROUND_ROBIN_EN
   logic [1:0] ptr;
   logic [1:0] probe;

   // The first requester at or above the pointer wins; the search wraps from 4 back to 1.
   always_comb begin
      pick  = 4'b0000;
      probe = ptr;
      for (int k = 0; k < 4; k++) begin
         probe = ptr + 2'(k);
         if (pick == 4'b0000 && rq[probe]) pick[probe] = 1'b1;
      end
   end
`else
   always_comb begin
      pick = rq & (~rq + 4'd1);
   end
`endif

   always_comb begin
      win_idx = 2'd0;
      if (pick[1]) win_idx = 2'd1;
      if (pick[2]) win_idx = 2'd2;
      if (pick[3]) win_idx = 2'd3;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         owner          <= 2'd0;
         ack            <= 4'b0000;
         data_r         <= '0;
         grant          <= 4'b0000;
         server_address <= '0;
         server_rq      <= 1'b0;
         server_wr_ni   <= 1'b0;
         server_dataW   <= '0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
         ptr            <= 2'd0;
`endif
      end else begin
         case (state)
            IDLE: begin
               // A server_ack still high from the last transaction must drop before a new request goes out.
               if (!server_ack && rq != 4'b0000) begin
                  server_address <= addr_in[win_idx];
                  server_wr_ni   <= wr_ni_in[win_idx];
                  server_dataW   <= data_w_in[win_idx];
                  server_rq      <= 1'b1;
                  grant          <= pick;
                  owner          <= win_idx;
                  state          <= SRV_REQ;
               end
            end
            SRV_REQ: begin
               if (server_ack) begin
                  server_rq  <= 1'b0;
                  ack[owner] <= 1'b1;
                  if (server_wr_ni) data_r[owner] <= server_dataR;
                  state      <= CLI_ACK;
               end
            end
            CLI_ACK: begin
               // A winner that dropped rq early sees ack for exactly one cycle here.
               if (!rq[owner]) begin
                  ack    <= 4'b0000;
                  data_r <= '0;
                  grant  <= 4'b0000;
`ifdef BUS_ARB_ROUND_ROBIN_EN
                  ptr    <= owner + 2'd1;
`endif
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   ack_matches_grant: assert property (@(posedge clk) disable iff (!reset) (ack != 4'b0000) |-> (ack == grant));
   grant_onehot:      assert property (@(posedge clk) disable iff (!reset) $onehot0(grant));
   rq_only_in_srv:    assert property (@(posedge clk) disable iff (!reset) server_rq |-> (state == SRV_REQ));

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb_bus_arbiter_rr: directed scoreboard bench for bus_arbiter_rr.
// Grant-order expectations follow BUS_ARB_ROUND_ROBIN_EN.
module tb_bus_arbiter_rr;
   localparam int DW = 8;
   localparam int AW = 4;
   localparam int SW = 16;

   logic                clk;
   logic                reset;
   logic [3:0][AW-1:0]  addr;
   logic [3:0]          rq;
   logic [3:0]          wr_ni;
   logic [3:0][DW-1:0]  dw;
   wire  [3:0]          acks;
   wire  [3:0][DW-1:0]  dr;
   logic [AW-1:0]       server_address;
   logic                server_rq;
   logic                server_wr_ni;
   logic [DW-1:0]       server_dataW;
   logic                server_ack;
   logic [DW-1:0]       server_dataR;
   logic [3:0]          grant;
   logic [1:0]          fsm_state;

   int n_checks = 0;
   int n_pass   = 0;
   logic [SW-1:0] exp_q[$];
   logic [3:0]    prev_acks;

   bus_arbiter_rr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset),
      .client_1_address(addr[0]), .client_1_rq(rq[0]), .client_1_wr_ni(wr_ni[0]), .client_1_dataW(dw[0]),
      .client_1_ack(acks[0]), .client_1_dataR(dr[0]),
      .client_2_address(addr[1]), .client_2_rq(rq[1]), .client_2_wr_ni(wr_ni[1]), .client_2_dataW(dw[1]),
      .client_2_ack(acks[1]), .client_2_dataR(dr[1]),
      .client_3_address(addr[2]), .client_3_rq(rq[2]), .client_3_wr_ni(wr_ni[2]), .client_3_dataW(dw[2]),
      .client_3_ack(acks[2]), .client_3_dataR(dr[2]),
      .client_4_address(addr[3]), .client_4_rq(rq[3]), .client_4_wr_ni(wr_ni[3]), .client_4_dataW(dw[3]),
      .client_4_ack(acks[3]), .client_4_dataR(dr[3]),
      .server_address(server_address), .server_rq(server_rq), .server_wr_ni(server_wr_ni),
      .server_dataW(server_dataW), .server_ack(server_ack), .server_dataR(server_dataR),
      .grant(grant), .fsm_state(fsm_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [SW-1:0] exp_word(input logic [3:0] g, input logic [DW-1:0] d);
      return {g, g, d};
   endfunction

   function automatic logic [DW-1:0] ack_data();
      logic [DW-1:0] d;
      d = '0;
      for (int i = 0; i < 4; i++) if (acks[i]) d |= dr[i];
      return d;
   endfunction

   // scoreboard: every rising client ack pops one expected {ack, grant, dataR}
   always @(negedge clk) begin : sb_mon
      logic [SW-1:0] e;
      if (!reset) begin
         prev_acks = 4'b0000;
      end else begin
         if ((acks & ~prev_acks) != 4'b0000) begin
            if (exp_q.size() == 0) begin
               check("sb_unexpected_ack", {acks, grant, ack_data()}, SW'(0));
            end else begin
               e = exp_q.pop_front();
               check("sb_txn", {acks, grant, ack_data()}, e);
            end
         end
         prev_acks = acks;
      end
   end

   // driver tasks
   task automatic set_client(input int i, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
      addr[i]  = a;
      wr_ni[i] = w;
      dw[i]    = d;
      rq[i]    = 1'b1;
   endtask

   task automatic wait_srv_rq(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!server_rq && cyc < 30);
      if (!server_rq) check("srv_rq_timeout", SW'(0), SW'(1));
   endtask

   task automatic wait_ack(output logic [3:0] who);
      int cyc;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (acks == 4'b0000 && cyc < 30);
      who = acks;
      if (acks == 4'b0000) check("ack_timeout", SW'(0), SW'(1));
   endtask

   task automatic serve(input int lat, input logic [DW-1:0] d);
      repeat (lat) @(negedge clk);
      server_ack   = 1'b1;
      server_dataR = d;
   endtask

   initial begin
      int         cyc;
      logic [3:0] who;
      logic [3:0] g;
      reset = 1'b0; rq = '0; addr = '0; wr_ni = '0; dw = '0;
      server_ack = 1'b0; server_dataR = '0;
      repeat (3) @(negedge clk);

      check("rst_state", SW'(fsm_state), SW'(0));
      check("rst_grant", SW'(grant), SW'(0));
      check("rst_server", SW'({server_rq, server_wr_ni, server_address, server_dataW}), SW'(0));
      check("rst_acks", SW'(acks), SW'(0));
      for (int i = 0; i < 4; i++) check("rst_dataR", SW'(dr[i]), SW'(0));
      reset = 1'b1;
      @(negedge clk);

      // single read by client 2
      set_client(1, 4'b0101, 1'b1, 8'h11);
      exp_q.push_back(exp_word(4'b0010, 8'hA5));
      wait_srv_rq(cyc);
      check("rd_latency", SW'(cyc), SW'(1));
      check("rd_grant", SW'(grant), SW'(4'b0010));
      check("rd_addr", SW'(server_address), SW'(4'b0101));
      check("rd_dir", SW'(server_wr_ni), SW'(1));
      addr[1]  = 4'b0000;
      wr_ni[1] = 1'b0;
      serve(3, 8'hA5);
      wait_ack(who);
      check("rd_addr_hold", SW'(server_address), SW'(4'b0101));
      check("rd_srv_rq_fall", SW'(server_rq), SW'(0));
      server_ack = 1'b0;
      rq[1]      = 1'b0;
      @(negedge clk);
      check("rd_release", {acks, grant, dr[1]}, SW'(0));

      // single write by client 4
      set_client(3, 4'b1111, 1'b0, 8'h3C);
      exp_q.push_back(exp_word(4'b1000, 8'h00));
      wait_srv_rq(cyc);
      check("wr_data", SW'(server_dataW), SW'(8'h3C));
      check("wr_dir", SW'(server_wr_ni), SW'(0));
      check("wr_addr", SW'(server_address), SW'(4'b1111));
      serve(1, 8'h77);
      wait_ack(who);
      server_ack = 1'b0;
      rq[3]      = 1'b0;
      @(negedge clk);

      // all four requesting continuously
      for (int i = 0; i < 4; i++) set_client(i, 4'(i + 8), 1'b1, 8'h00);
      for (int t = 0; t < 5; t++) begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
         g = 4'(1 << (t % 4));
`else
         g = 4'b0001;
`endif
         exp_q.push_back(exp_word(g, 8'(8'h40 + t)));
         wait_srv_rq(cyc);
         check("cont_grant", SW'(grant), SW'(g));
         serve(1, 8'(8'h40 + t));
         wait_ack(who);
         server_ack = 1'b0;
         rq = rq & ~who;
         if (t == 4) begin
            rq = 4'b0000;
         end else begin
            @(negedge clk);
            rq = rq | who;
         end
      end
      @(negedge clk);

      // reset while client 3 is being served
      set_client(2, 4'h3, 1'b1, 8'h00);
      wait_srv_rq(cyc);
      set_client(0, 4'h1, 1'b1, 8'h00);
      #1 reset = 1'b0;
      #1;
      check("mid_rst_srv", SW'({server_rq, grant, fsm_state}), SW'(0));
      check("mid_rst_acks", SW'(acks), SW'(0));
      for (int i = 0; i < 4; i++) check("mid_rst_dataR", SW'(dr[i]), SW'(0));
      @(negedge clk);
      reset = 1'b1;
      exp_q.push_back(exp_word(4'b0001, 8'h5A));
      wait_srv_rq(cyc);
      check("post_rst_grant", SW'(grant), SW'(4'b0001));
      serve(0, 8'h5A);
      wait_ack(who);
      server_ack = 1'b0;
      rq[0]      = 1'b0;
      exp_q.push_back(exp_word(4'b0100, 8'h6B));
      wait_srv_rq(cyc);
      check("pending_grant", SW'(grant), SW'(4'b0100));
      serve(0, 8'h6B);
      wait_ack(who);
      server_ack = 1'b0;
      rq[2]      = 1'b0;
      @(negedge clk);

      // client 3 drops rq before its ack; client 1 waits behind it
      set_client(2, 4'h6, 1'b1, 8'h00);
      exp_q.push_back(exp_word(4'b0100, 8'hC3));
      wait_srv_rq(cyc);
      rq[2] = 1'b0;
      set_client(0, 4'h2, 1'b0, 8'h99);
      serve(2, 8'hC3);
      wait_ack(who);
      server_ack = 1'b0;
      check("early_who", SW'(who), SW'(4'b0100));
      @(negedge clk);
      check("early_ack_len", SW'(acks), SW'(0));
      check("early_idle", SW'(grant), SW'(0));
      exp_q.push_back(exp_word(4'b0001, 8'h00));
      wait_srv_rq(cyc);
      check("after_early_grant", SW'(grant), SW'(4'b0001));
      check("after_early_data", SW'(server_dataW), SW'(8'h99));
      serve(0, 8'h00);

      // server_ack stays high after the handshake; client 2 must wait for it to drop
      wait_ack(who);
      rq[0] = 1'b0;
      set_client(1, 4'h9, 1'b1, 8'h00);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("sticky_no_rq", SW'(server_rq), SW'(0));
      end
      server_ack = 1'b0;
      exp_q.push_back(exp_word(4'b0010, 8'hE7));
      wait_srv_rq(cyc);
      check("sticky_latency", SW'(cyc), SW'(1));
      check("sticky_grant", SW'(grant), SW'(4'b0010));
      serve(1, 8'hE7);
      wait_ack(who);
      server_ack = 1'b0;
      rq[1]      = 1'b0;
      @(negedge clk);
      check("final_idle", SW'({grant, acks, fsm_state}), SW'(0));
      check("sb_drained", SW'(exp_q.size()), SW'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/bus_arbiter_rr.md
# bus_arbiter_rr

Four-client, single-server bus arbiter. It grants one pending client request at a time to the shared server port and forwards that client's address, direction and write data. It returns the server's read data and acknowledge to the granted client. It sits between client 1..4 and the server, on the same signals the bus monitor observes; grant order is round-robin or fixed priority per build option.

## Interface
- DATA_WIDTH, 8, width of dataW/dataR buses
- ADDR_WIDTH, 4, width of address buses
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- client_N_address  input  ADDR_WIDTH  N=1..4, request address
- client_N_rq  input  1  N=1..4, request, held until ack seen
- client_N_wr_ni  input  1  N=1..4, 1 = read, 0 = write
- client_N_dataW  input  DATA_WIDTH  N=1..4, write data
- client_N_ack  output  1  N=1..4, request served
- client_N_dataR  output  DATA_WIDTH  N=1..4, read data, valid while ack=1
- server_address  output  ADDR_WIDTH  forwarded address
- server_rq  output  1  forwarded request
- server_wr_ni  output  1  forwarded direction
- server_dataW  output  DATA_WIDTH  forwarded write data
- server_ack  input  1  server done
- server_dataR  input  DATA_WIDTH  server read data, valid with server_ack
- grant  output  4  one-hot current owner, bit0 = client 1, 0 when idle

## Operation
- All outputs are registered. On reset=0, all outputs clear to 0 immediately, FSM goes to IDLE and the priority pointer goes to client 1. This applies mid-transaction as well.
- The FSM has three states: IDLE, SRV_REQ and CLI_ACK.
- IDLE:
  - Sample all client_N_rq.
  - If any request is high, select a winner, latch its address, wr_ni and dataW into the server_* outputs, set grant, assert server_rq, and go to SRV_REQ.
  - Entry into IDLE requires server_ack=0; if server_ack is still high, stay in IDLE.
- SRV_REQ:
  - Hold server_* stable.
  - When server_ack is sampled 1, clear server_rq.
  - If wr_ni=1, latch server_dataR into the winner's client_dataR; writes leave dataR at 0.
  - Assert the winner's client_ack and go to CLI_ACK.
- CLI_ACK:
  - Hold ack and dataR.
  - When the winner's client_rq is sampled 0, clear ack, dataR and grant. Advance the pointer to winner+1 (wrapping 4→1) and go to IDLE.
- Client inputs are sampled only on the IDLE→SRV_REQ edge. Later changes to address, data or wr_ni are ignored for that transaction.
- If the winner drops rq before its ack (protocol violation), the server transaction still completes. Ack is then asserted for exactly one cycle.
- Requests from non-granted clients stay pending. They are never acked and never dropped by the arbiter.
- At most one client_ack is high at any time, and it matches grant.

## Timing
- The earliest server_rq is 1 cycle after a client rq is sampled.
- server_rq falls on the cycle after server_ack is sampled; client_ack rises on that same edge.
- client_ack falls 1 cycle after client rq is sampled low.
- Minimum transaction: rq sampled at cycle 0, server_rq at 1. With server_ack sampled at 1, ack is at 2. With rq sampled low at 2, ack falls at 3 and IDLE is reached at 3. The next grant is possible at cycle 4.
- Simultaneous requests in the same cycle are resolved by the arbitration rule. There is no starvation under round-robin.

## Configuration
- BUS_ARB_ROUND_ROBIN_EN defined:
  - The winner is the first requester found searching from the pointer upward with wrap.
  - The pointer moves to winner+1 after each completed transaction.
- BUS_ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority: client 1 > 2 > 3 > 4.
  - The pointer logic is absent and grant ignores history.

## Test plan
- Single read: client 2 rq with address 4'b0101 and wr_ni=1. Server returns dataR 8'hA5 with ack after 3 cycles. Required: server_address=0101, server_wr_ni=1, then client_2_ack=1 with client_2_dataR=A5, then grant=0 after rq drops.
- Single write: client 4 with address 4'b1111, dataW 8'h3C, wr_ni=0. Required: server_dataW=3C and server_wr_ni=0; client_4_ack=1 with client_4_dataR=0.
- All four rq high continuously, server ack 1 cycle after each rq:
  - With ROUND_ROBIN_EN: grant order 0001, 0010, 0100, 1000, 0001.
  - Without it: grant stays 0001 for every transaction.
- Reset mid-operation: reset=0 while in SRV_REQ with server_rq=1. Required: server_rq, grant, all acks and all dataR are 0 in the same cycle. After release, the first grant goes to the lowest-index requester (client 1 if requesting).
- Early drop: client 3 drops rq during SRV_REQ. Required: the server transaction completes and client_3_ack is high for exactly 1 cycle. Then IDLE; a pending client 1 is granted next.
- Sticky server_ack: server_ack held high for 2 extra cycles after the client handshake. Required: no new server_rq until server_ack=0.
